// File: rtl/buff_pkg.sv
// Shared types and defaults for the multi-channel FIFO.
// Imported by the channel buffer and the top level.
package buff_pkg;

    localparam int DEF_ALMOST_FULL  = 12;
    localparam int DEF_ALMOST_EMPTY = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } flags_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_channel.sv
// One circular-buffer FIFO channel driven by pre-qualified accept strobes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fifo_channel
    import buff_pkg::*;
#(
    parameter int data_width           = 8,
    parameter int length_as_power_of_2 = 4,
    parameter int almost_full_level    = DEF_ALMOST_FULL,
    parameter int almost_empty_level   = DEF_ALMOST_EMPTY
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            push_accept,
    input  logic                            pop_accept,
    input  logic [data_width-1:0]           push_data,
    output logic [length_as_power_of_2:0]   count,
    output flags_t                          flags,
    output logic [data_width-1:0]           head_data
);

    localparam int L     = length_as_power_of_2;
    localparam int DEPTH = 1 << L;
    localparam logic [L:0] W_DEPTH = {1'b1, {L{1'b0}}};
    localparam logic [L:0] W_AF    = (L+1)'(almost_full_level);
    localparam logic [L:0] W_AE    = (L+1)'(almost_empty_level);

    logic [data_width-1:0] r_mem [DEPTH];
    logic [L:0]            r_wr_ptr;
    logic [L:0]            r_rd_ptr;
    logic [L:0]            w_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop_accept)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is never cleared; only the pointers define valid entries.
    always_ff @(posedge clock) begin
        if (push_accept) r_mem[r_wr_ptr[L-1:0]] <= push_data;
    end

    assign w_count            = r_wr_ptr - r_rd_ptr;
    assign count              = w_count;
    assign head_data          = r_mem[r_rd_ptr[L-1:0]];
    assign flags.full         = (w_count == W_DEPTH);
    assign flags.empty        = (w_count == '0);
    assign flags.almost_full  = (w_count >= W_AF);
    assign flags.almost_empty = (w_count <= W_AE);

endmodule

// File: rtl/multi_channel_fifo.sv
// Several independent FIFOs behind one addressed push port and one pop port.
// Owns address decode, sticky error flags and the registered pop output.
module multi_channel_fifo
    import buff_pkg::*;
#(
    parameter int data_width           = 8,
    parameter int length_as_power_of_2 = 4,
    parameter int channel_count        = 4,
    parameter int almost_full_level    = DEF_ALMOST_FULL,
    parameter int almost_empty_level   = DEF_ALMOST_EMPTY
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [$clog2(channel_count)-1:0] push_address,
    input  logic                             push_enable,
    input  logic [data_width-1:0]            data_in,
    input  logic [$clog2(channel_count)-1:0] pop_address,
    input  logic                             pop_enable,
    input  logic                             error_clear,
    output logic [data_width-1:0]            data_out,
    output logic                             data_out_valid,
    output logic [length_as_power_of_2:0]    pop_level,
    output logic [channel_count-1:0]         full,
    output logic [channel_count-1:0]         empty,
    output logic [channel_count-1:0]         almost_full,
    output logic [channel_count-1:0]         almost_empty,
    output logic [channel_count-1:0]         overflow,
    output logic [channel_count-1:0]         underflow
);

    localparam int AW = addr_width(channel_count);
    localparam int L  = length_as_power_of_2;
    localparam int N  = channel_count;

    flags_t                w_flags [N];
    logic [L:0]            w_count [N];
    logic [data_width-1:0] w_head  [N];
    logic [N-1:0]          w_full;
    logic [N-1:0]          w_empty;
    logic [N-1:0]          w_af;
    logic [N-1:0]          w_ae;
    logic [N-1:0]          w_push_acc;
    logic [N-1:0]          w_pop_acc;
    logic [N-1:0]          w_push_drop;
    logic [N-1:0]          w_pop_refuse;
    logic [L:0]            w_pop_level;
    logic [data_width-1:0] w_pop_data;

    logic [data_width-1:0] r_data_out;
    logic                  r_data_out_valid;
    logic [N-1:0]          r_overflow;
    logic [N-1:0]          r_underflow;

    for (genvar c = 0; c < N; c++) begin : g_ch
        fifo_channel #(
            .data_width           (data_width),
            .length_as_power_of_2 (length_as_power_of_2),
            .almost_full_level    (almost_full_level),
            .almost_empty_level   (almost_empty_level)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .push_accept (w_push_acc[c]),
            .pop_accept  (w_pop_acc[c]),
            .push_data   (data_in),
            .count       (w_count[c]),
            .flags       (w_flags[c]),
            .head_data   (w_head[c])
        );
        assign w_full[c]  = w_flags[c].full;
        assign w_empty[c] = w_flags[c].empty;
        assign w_af[c]    = w_flags[c].almost_full;
        assign w_ae[c]    = w_flags[c].almost_empty;
    end

    // Out-of-range addresses match no channel and are ignored.
    always_comb begin
        w_push_acc   = '0;
        w_pop_acc    = '0;
        w_push_drop  = '0;
        w_pop_refuse = '0;
        w_pop_level  = '0;
        w_pop_data   = '0;
        for (int c = 0; c < N; c++) begin
            if (pop_enable && pop_address == AW'(c)) begin
                w_pop_acc[c]    = !w_empty[c];
                w_pop_refuse[c] = w_empty[c];
            end
            if (push_enable && push_address == AW'(c)) begin
                w_push_acc[c]  = !w_full[c] || w_pop_acc[c];
                w_push_drop[c] = w_full[c] && !w_pop_acc[c];
            end
            if (pop_address == AW'(c)) begin
                w_pop_level = w_count[c];
                w_pop_data  = w_head[c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_overflow       <= '0;
            r_underflow      <= '0;
        end else begin
            r_overflow  <= (error_clear ? '0 : r_overflow) | w_push_drop;
            r_underflow <= (error_clear ? '0 : r_underflow) | w_pop_refuse;
            if (|w_pop_acc) begin
                r_data_out       <= w_pop_data;
                r_data_out_valid <= 1'b1;
            end else begin
                r_data_out       <= '0;
                r_data_out_valid <= 1'b0;
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
    assign pop_level      = w_pop_level;
    assign full           = w_full;
    assign empty          = w_empty;
    assign almost_full    = w_af;
    assign almost_empty   = w_ae;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_multi_channel_fifo.sv
// Bench for multi_channel_fifo: per-channel queue model plus pop scoreboard,
// a table of explicit flag vectors, and hand-written corner sequences.
module tb_multi_channel_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] push_address;
    logic       push_enable;
    logic [7:0] data_in;
    logic [1:0] pop_address;
    logic       pop_enable;
    logic       error_clear;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [2:0] pop_level;
    logic [3:0] full, empty, almost_full, almost_empty, overflow, underflow;

    multi_channel_fifo #(
        .data_width           (8),
        .length_as_power_of_2 (2),
        .channel_count        (4),
        .almost_full_level    (3),
        .almost_empty_level   (1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .push_address   (push_address),
        .push_enable    (push_enable),
        .data_in        (data_in),
        .pop_address    (pop_address),
        .pop_enable     (pop_enable),
        .error_clear    (error_clear),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .pop_level      (pop_level),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       pe;
        logic [1:0] pa;
        logic [7:0] d;
        logic       oe;
        logic [1:0] oa;
        logic [3:0] x_full;
        logic [3:0] x_empty;
        logic [3:0] x_af;
        logic [3:0] x_ae;
        logic [3:0] x_of;
        logic       x_valid;
        logic [7:0] x_dout;
    } vec_t;

    vec_t       tv [11];
    logic [7:0] mq [4][$];
    logic [7:0] sb [$];
    logic [3:0] m_of, m_uf;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rs, input logic pe, input logic [1:0] pa,
                       input logic [7:0] d, input logic oe, input logic [1:0] oa,
                       input logic ec);
        logic       pop_ok, push_ok;
        logic [3:0] drop, refuse, m_empty, m_full;
        logic [7:0] exp_d;
        reset = rs; push_enable = pe; push_address = pa; data_in = d;
        pop_enable = oe; pop_address = oa; error_clear = ec;
        pop_ok = 1'b0; push_ok = 1'b0; drop = '0; refuse = '0;
        if (!rs) begin
            pop_ok  = oe && (mq[oa].size() > 0);
            push_ok = pe && ((mq[pa].size() < 4) || (pop_ok && oa == pa));
            if (pe && !push_ok) drop[pa] = 1'b1;
            if (oe && !pop_ok) refuse[oa] = 1'b1;
            if (pop_ok) sb.push_back(mq[oa].pop_front());
            if (push_ok) mq[pa].push_back(d);
        end
        @(posedge clock);
        #1;
        if (rs) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            sb.delete();
            m_of = '0;
            m_uf = '0;
        end else begin
            m_of = (ec ? 4'b0 : m_of) | drop;
            m_uf = (ec ? 4'b0 : m_uf) | refuse;
        end
        if (pop_ok && sb.size() > 0) begin
            exp_d = sb.pop_front();
            chk("pop_valid", 32'(data_out_valid), 32'd1);
            chk("pop_data", 32'(data_out), 32'(exp_d));
        end else begin
            chk("idle_valid", 32'(data_out_valid), 32'd0);
            chk("idle_data", 32'(data_out), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            m_empty[i] = (mq[i].size() == 0);
            m_full[i]  = (mq[i].size() == 4);
        end
        chk("empty", 32'(empty), 32'(m_empty));
        chk("full", 32'(full), 32'(m_full));
        chk("overflow", 32'(overflow), 32'(m_of));
        chk("underflow", 32'(underflow), 32'(m_uf));
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic pop(input logic [1:0] a);
        cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, a, 1'b0);
    endtask

    initial begin
        tv[0]  = '{1'b1, 2'd2, 8'd1, 1'b0, 2'd0, 4'b0000, 4'b1011, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'd0};
        tv[1]  = '{1'b1, 2'd2, 8'd2, 1'b0, 2'd0, 4'b0000, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 1'b0, 8'd0};
        tv[2]  = '{1'b1, 2'd2, 8'd3, 1'b0, 2'd0, 4'b0000, 4'b1011, 4'b0100, 4'b1011, 4'b0000, 1'b0, 8'd0};
        tv[3]  = '{1'b1, 2'd2, 8'd4, 1'b0, 2'd0, 4'b0100, 4'b1011, 4'b0100, 4'b1011, 4'b0000, 1'b0, 8'd0};
        tv[4]  = '{1'b1, 2'd2, 8'd5, 1'b0, 2'd0, 4'b0100, 4'b1011, 4'b0100, 4'b1011, 4'b0100, 1'b0, 8'd0};
        tv[5]  = '{1'b1, 2'd2, 8'd6, 1'b0, 2'd0, 4'b0100, 4'b1011, 4'b0100, 4'b1011, 4'b0100, 1'b0, 8'd0};
        tv[6]  = '{1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 4'b0000, 4'b1011, 4'b0100, 4'b1011, 4'b0100, 1'b1, 8'd1};
        tv[7]  = '{1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 4'b0000, 4'b1011, 4'b0000, 4'b1011, 4'b0100, 1'b1, 8'd2};
        tv[8]  = '{1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 4'b0000, 4'b1011, 4'b0000, 4'b1111, 4'b0100, 1'b1, 8'd3};
        tv[9]  = '{1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0100, 1'b1, 8'd4};
        tv[10] = '{1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0100, 1'b0, 8'd0};

        m_of = '0;
        m_uf = '0;
        cyc(1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b0);
        idle();
        idle();
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ae", 32'(almost_empty), 32'hF);
        chk("rst_af", 32'(almost_full), 32'h0);
        chk("rst_valid", 32'(data_out_valid), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_level", 32'(pop_level), 32'd0);

        for (int i = 0; i < 11; i++) begin
            cyc(1'b0, tv[i].pe, tv[i].pa, tv[i].d, tv[i].oe, tv[i].oa, 1'b0);
            chk($sformatf("tv%0d_full", i), 32'(full), 32'(tv[i].x_full));
            chk($sformatf("tv%0d_empty", i), 32'(empty), 32'(tv[i].x_empty));
            chk($sformatf("tv%0d_af", i), 32'(almost_full), 32'(tv[i].x_af));
            chk($sformatf("tv%0d_ae", i), 32'(almost_empty), 32'(tv[i].x_ae));
            chk($sformatf("tv%0d_of", i), 32'(overflow), 32'(tv[i].x_of));
            chk($sformatf("tv%0d_valid", i), 32'(data_out_valid), 32'(tv[i].x_valid));
            chk($sformatf("tv%0d_dout", i), 32'(data_out), 32'(tv[i].x_dout));
        end
        cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1);
        chk("of_cleared", 32'(overflow), 32'h0);

        push(2'd0, 8'd10);
        push(2'd0, 8'd11);
        push(2'd3, 8'd20);
        push(2'd3, 8'd21);
        chk("ilv_empty", 32'(empty), 32'b0110);
        pop(2'd3);
        chk("ilv_d0", 32'(data_out), 32'd20);
        pop(2'd0);
        chk("ilv_d1", 32'(data_out), 32'd10);
        pop(2'd3);
        chk("ilv_d2", 32'(data_out), 32'd21);
        pop(2'd0);
        chk("ilv_d3", 32'(data_out), 32'd11);
        chk("ilv_empty_end", 32'(empty), 32'hF);

        for (int i = 1; i <= 4; i++) push(2'd1, 8'(i));
        chk("fill_level_pa0", 32'(pop_level), 32'd0);
        cyc(1'b0, 1'b1, 2'd1, 8'd5, 1'b1, 2'd1, 1'b0);
        chk("full_pp_data", 32'(data_out), 32'd1);
        chk("full_pp_full", 32'(full[1]), 32'd1);
        chk("full_pp_level", 32'(pop_level), 32'd4);
        chk("full_pp_of", 32'(overflow), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            pop(2'd1);
            chk($sformatf("full_pp_tail%0d", i), 32'(data_out), 32'(i));
        end

        cyc(1'b0, 1'b1, 2'd0, 8'd7, 1'b1, 2'd0, 1'b0);
        chk("ep_valid", 32'(data_out_valid), 32'd0);
        chk("ep_uf", 32'(underflow), 32'b0001);
        chk("ep_level", 32'(pop_level), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1);
        chk("ep_uf_clr", 32'(underflow), 32'd0);
        pop(2'd0);
        chk("ep_data", 32'(data_out), 32'd7);

        cyc(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 2'd2, 1'b1);
        chk("clr_vs_new_uf", 32'(underflow), 32'b0100);

        for (int i = 0; i < 5; i++) push(2'd1, 8'(8'h30 + i));
        chk("wrap_full", 32'(full), 32'b0010);
        chk("wrap_of", 32'(overflow[1]), 32'd1);
        pop(2'd1);
        chk("wrap_head", 32'(data_out), 32'h30);
        cyc(1'b1, 1'b0, 2'd0, 8'd0, 1'b1, 2'd1, 1'b0);
        chk("mid_rst_empty", 32'(empty[1]), 32'd1);
        chk("mid_rst_valid", 32'(data_out_valid), 32'd0);
        chk("mid_rst_of", 32'(overflow), 32'd0);
        chk("mid_rst_uf", 32'(underflow), 32'd0);
        pop(2'd1);
        chk("post_rst_uf", 32'(underflow), 32'b0010);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_channel_fifo.md
Name: multi_channel_fifo

Overview:
- Parametrised successor to the single addressed FIFO: `channel_count` independent circular-buffer FIFOs behind one shared push port and one shared pop port, each port selecting its channel by address.
- Adds per-channel almost-full/almost-empty flags, sticky overflow/underflow error flags, simultaneous push and pop on the same channel, and a registered `data_out_valid`.
- Sits between the UART byte path and its consumers, buffering several logical streams.

Parameters:
- data_width, 8, width of one entry in bits.
- length_as_power_of_2, 4, per-channel depth = 2**length_as_power_of_2.
- channel_count, 4, number of channels, >= 2.
- almost_full_level, 12, almost_full[c] asserted when count[c] >= this value.
- almost_empty_level, 2, almost_empty[c] asserted when count[c] <= this value.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- push_address  in  $clog2(channel_count)  channel written by push.
- push_enable  in  1  push request.
- data_in  in  data_width  entry to push.
- pop_address  in  $clog2(channel_count)  channel read by pop.
- pop_enable  in  1  pop request.
- error_clear  in  1  clears all sticky error flags.
- data_out  out  data_width  popped entry, registered.
- data_out_valid  out  1  data_out holds an entry popped last cycle.
- pop_level  out  length_as_power_of_2+1  count of the channel at pop_address (combinational).
- full  out  channel_count  per channel, count == depth.
- empty  out  channel_count  per channel, count == 0.
- almost_full  out  channel_count  per-channel threshold flag.
- almost_empty  out  channel_count  per-channel threshold flag.
- overflow  out  channel_count  sticky: a push was dropped on that channel.
- underflow  out  channel_count  sticky: a pop was refused on that channel.

Behaviour:
- Reset (reset=1 at posedge):
  - All channel pointers go to 0.
  - data_out=0, data_out_valid=0, overflow=0, underflow=0.
  - Flags then read empty=all 1, full=0, almost_empty=all 1, almost_full=0.
  - Reset mid-operation discards all stored entries. Storage RAM is not cleared.
- Pointers:
  - Each channel has wr_ptr and rd_ptr, length_as_power_of_2+1 bits wide, that wrap naturally.
  - Index = low length_as_power_of_2 bits.
  - count = wr_ptr - rd_ptr, modulo 2**(length_as_power_of_2+1).
- Flags: full, empty, almost_full, almost_empty and pop_level are combinational from the current pointers.
- Push accepted iff push_enable && !full[push_address]:
  - Store data_in at wr_ptr; wr_ptr+1.
  - Push to a full channel is dropped, sets overflow[push_address], and leaves the stored data untouched.
- Pop accepted iff pop_enable && !empty[pop_address]:
  - Next cycle data_out = entry at rd_ptr and data_out_valid=1; rd_ptr+1.
  - Pop latency is exactly 1 cycle.
- Refused or absent pop:
  - Next cycle data_out=0 and data_out_valid=0.
  - A refused pop (pop_enable on an empty channel) sets underflow[pop_address].
- Same channel, push and pop in the same cycle:
  - Evaluate against the pre-edge count.
  - Empty channel: push accepted, pop refused (no bypass), underflow set; count goes to 1.
  - Full channel: both accepted (pop frees a slot); count stays at depth; pushed data lands in the slot vacated by the old head.
  - Otherwise: both accepted, count unchanged.
- Different channels: push and pop are fully independent.
- error_clear:
  - Clears overflow and underflow at the posedge.
  - A new error in the same cycle wins, so the flag stays set.
- Out-of-range addresses (address >= channel_count, non-power-of-2 counts): push/pop ignored, no flag change, pop_level=0.

Decomposition:
- Package buff_pkg:
  - channel address width function.
  - Flag record typedef (full, empty, almost_full, almost_empty).
  - Defaults for thresholds.
- Sub-module fifo_channel, instantiated channel_count times in a generate loop:
  - Holds one circular buffer.
  - Takes push_accept/pop_accept strobes and data; exposes count, flags and head data.
- Top level owns address decode, error flags and the data_out register.

Test Plan (length_as_power_of_2=2, channel_count=4, almost_full_level=3, almost_empty_level=1):
- Reset, then idle 2 cycles -> empty=4'b1111, full=0, data_out_valid=0, data_out=0.
- Push 1..6 to ch2 on consecutive cycles -> full[2]=1 after the 4th push; almost_full[2]=1 from count 3; overflow[2]=1 after the 5th push; pops then return 1,2,3,4 with valid one cycle after each pop, then empty[2]=1.
- Interleave: push 10,11 to ch0 and 20,21 to ch3, then pop ch3, ch0, ch3, ch0 -> data_out 20,10,21,11; other channels' flags unchanged.
- Fill ch1 with 1..4, then push 5 and pop ch1 in the same cycle -> data_out=1 valid, full[1] stays 1, no overflow; the following pops return 2,3,4,5.
- Pop empty ch0 together with push 7 to ch0 -> data_out_valid=0, underflow[0]=1, pop_level=1; assert error_clear -> underflow=0; the next pop returns 7.
- Push 4 entries to ch1 with wrap (pointers past 4), assert reset mid-stream -> next cycle empty[1]=1, data_out_valid=0, overflow=0.
